operand_collector: RTL and testbench
====================================

OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each collected value; legal range 1..32.
REQ-002 Parameter DEPTH, default 4: number of collection slots; legal range 1..16.
REQ-003 Parameter CW, default $clog2(DEPTH+1): width of the count outputs; derived, not overridden.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 putFlag  input  1  when high, value is offered for collection this cycle.
REQ-007 value  input  WIDTH  data offered with putFlag.
REQ-008 out_ack  input  1  consumer acknowledge of a published batch.
REQ-009 ready  output  1  high when a putFlag this cycle will be accepted.
REQ-010 out_data  output  DEPTH*WIDTH  published slots; slot i occupies bits [i*WIDTH +: WIDTH].
REQ-011 out_valid  output  DEPTH  bit i high when published slot i holds collected data.
REQ-012 out_count  output  CW  number of valid slots in the published batch.
REQ-013 done  output  1  high while a published batch awaits out_ack.
REQ-014 overflow  output  1  sticky flag: at least one offered value was dropped.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, COLLECT and HOLD.
REQ-016 IDLE: putFlag=1 SHALL write value into slot 0, set the internal count to 1 and go to COLLECT; putFlag=0 SHALL stay in IDLE.
REQ-017 COLLECT with putFlag=1 and count<DEPTH SHALL write value into slot[count] and increment count by 1 (one value per cycle).
REQ-018 COLLECT with putFlag=1 and count==DEPTH SHALL drop value, leave slots and count unchanged, and set overflow.
REQ-019 COLLECT with putFlag=0 SHALL publish on that edge: out_data <= slots (unfilled slots read 0), out_valid <= (1<<count)-1, out_count <= count, done <= 1, next state HOLD.
REQ-020 On publish, internal slots SHALL clear to 0 and the internal count to 0 on the same edge.
REQ-021 Latency: done SHALL rise on the first posedge at which putFlag is sampled low in COLLECT.
REQ-022 HOLD: out_data, out_valid, out_count and done SHALL remain stable until out_ack is sampled high.
REQ-023 HOLD with out_ack=1 SHALL clear done and out_valid and set out_count to 0 on that edge; out_data SHALL retain its last value.
REQ-024 HOLD with out_ack=1 and putFlag=1 in the same cycle SHALL also write value into slot 0, set count to 1 and go to COLLECT; with putFlag=0 it SHALL go to IDLE.
REQ-025 HOLD with out_ack=0 and putFlag=1 SHALL drop value and set overflow.
REQ-026 ready SHALL be combinational: 1 in IDLE; 1 in COLLECT when count<DEPTH; 1 in HOLD only when out_ack=1; 0 otherwise.
REQ-027 overflow SHALL clear on the edge where out_ack is accepted in HOLD, unless a drop occurs on that same edge, in which case it stays set.
REQ-028 out_ack sampled outside HOLD SHALL have no effect.
REQ-029 DEPTH=1: the first value fills the batch; each further putFlag in COLLECT SHALL set overflow.

Reset
REQ-030 reset=1 SHALL, on the next posedge, force state IDLE, all slots, count, out_data, out_valid, out_count, done and overflow to 0.
REQ-031 reset SHALL take priority over putFlag and out_ack in the same cycle.
REQ-032 reset asserted mid-COLLECT or in HOLD SHALL discard the partial or published batch with no publish and no done pulse.

Verification (WIDTH=8, DEPTH=4)
REQ-033 putFlag high for 3 cycles with values 0x11, 0x22, 0x33, then low -> next edge: done=1, out_valid=4'b0111, out_count=3, out_data=0x00332211.
REQ-034 putFlag high for 6 cycles with values 1..6, then low -> out_data=0x04030201, out_count=4, overflow=1; ready=0 during the 5th and 6th put cycles.
REQ-035 Batch published with out_ack held 0 for 5 cycles, putFlag=1 with value 0x77 in cycle 3 -> outputs unchanged throughout, 0x77 dropped, overflow=1; out_ack=1 -> done=0, out_valid=0, overflow=0.
REQ-036 In HOLD, out_ack=1 with putFlag=1 and value 0xAA in the same cycle -> done=0, state COLLECT, count=1; putFlag low next cycle -> out_valid=4'b0001, out_data[7:0]=0xAA.
REQ-037 reset=1 after 2 collected values -> next edge: all outputs 0, state IDLE; no done pulse is ever observed.
REQ-038 DEPTH=1 instance: putFlag high 2 cycles with values 0x5A, 0x5B -> out_data=0x5A, out_count=1, overflow=1.

Source files
------------

// File: rtl/operand_collector.sv
// operand_collector
//   Gathers up to DEPTH values of WIDTH bits offered one per cycle with
//   putFlag, then publishes the whole batch when putFlag drops. The published
//   batch is held until the consumer acknowledges it. Values offered while
//   the batch is full, or while a published batch is unacknowledged, are
//   dropped and flagged on the sticky overflow output.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous active-high reset
//   putFlag   : a value is offered this cycle
//   value     : offered data (WIDTH bits)
//   out_ack   : consumer acknowledge of the published batch
//   ready     : combinational, an offer this cycle will be accepted
//   out_data  : published slots, slot i at [i*WIDTH +: WIDTH]
//   out_valid : bit i set when published slot i holds data
//   out_count : number of valid published slots
//   done      : published batch awaiting out_ack
//   overflow  : sticky, at least one offered value was dropped
module operand_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   putFlag,
    input  logic [WIDTH-1:0]       value,
    input  logic                   out_ack,
    output logic                   ready,
    output logic [DEPTH*WIDTH-1:0] out_data,
    output logic [DEPTH-1:0]       out_valid,
    output logic [CW-1:0]          out_count,
    output logic                   done,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DEPTH*WIDTH-1:0] r_slots;
    logic [CW-1:0]          r_count;
    logic [DEPTH*WIDTH-1:0] r_out_data;
    logic [DEPTH-1:0]       r_out_valid;
    logic [CW-1:0]          r_out_count;
    logic                   r_done;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_ready;
    logic                   w_start;    // value goes to slot 0, new batch
    logic                   w_append;   // value goes to slot[count]
    logic                   w_publish;
    logic                   w_ack;
    logic                   w_drop;
    logic [DEPTH-1:0]       w_valid_mask;

    assign w_full = (r_count >= CW'(DEPTH));

    // Thermometer mask of the slots currently filled, i.e. (1<<count)-1.
    always_comb begin
        w_valid_mask = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_mask[i] = (CW'(i) < r_count);
        end
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_start     = 1'b0;
        w_append    = 1'b0;
        w_publish   = 1'b0;
        w_ack       = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (putFlag) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                w_ready = ~w_full;
                if (putFlag) begin
                    if (w_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_append = 1'b1;
                    end
                end else begin
                    w_publish   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_ready = out_ack;
                if (out_ack) begin
                    w_ack = 1'b1;
                    if (putFlag) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_COLLECT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_drop = putFlag;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, collection slots and published outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_slots     <= {(DEPTH*WIDTH){1'b0}};
            r_count     <= {CW{1'b0}};
            r_out_data  <= {(DEPTH*WIDTH){1'b0}};
            r_out_valid <= {DEPTH{1'b0}};
            r_out_count <= {CW{1'b0}};
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Slots above slot 0 are already zero whenever a batch starts,
            // because they are cleared at every publish and at reset.
            if (w_start) begin
                r_slots[WIDTH-1:0] <= value;
                r_count            <= CW'(1);
            end else if (w_append) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_count == CW'(i)) begin
                        r_slots[i*WIDTH +: WIDTH] <= value;
                    end
                end
                r_count <= r_count + CW'(1);
            end else if (w_publish) begin
                r_out_data  <= r_slots;
                r_out_valid <= w_valid_mask;
                r_out_count <= r_count;
                r_done      <= 1'b1;
                r_slots     <= {(DEPTH*WIDTH){1'b0}};
                r_count     <= {CW{1'b0}};
            end
            // out_data deliberately keeps the last batch after acknowledge.
            if (w_ack) begin
                r_done      <= 1'b0;
                r_out_valid <= {DEPTH{1'b0}};
                r_out_count <= {CW{1'b0}};
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ack) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign ready     = w_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign done      = r_done;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: a per-cycle vector table on a DEPTH=4
// instance, scoreboard-checked random batches, and a DEPTH=1 instance.
module tb_operand_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        put;
    logic [7:0]  val;
    logic        ack;
    logic        rdy;
    logic [31:0] odata;
    logic [3:0]  ovalid;
    logic [2:0]  ocount;
    logic        odone;
    logic        oovf;

    logic        put1;
    logic [7:0]  val1;
    logic        ack1;
    logic        rdy1;
    logic [7:0]  odata1;
    logic [0:0]  ovalid1;
    logic [0:0]  ocount1;
    logic        odone1;
    logic        oovf1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_collector #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .putFlag(put), .value(val), .out_ack(ack),
        .ready(rdy), .out_data(odata), .out_valid(ovalid), .out_count(ocount),
        .done(odone), .overflow(oovf)
    );

    operand_collector #(.WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .putFlag(put1), .value(val1), .out_ack(ack1),
        .ready(rdy1), .out_data(odata1), .out_valid(ovalid1), .out_count(ocount1),
        .done(odone1), .overflow(oovf1)
    );

    typedef struct {
        logic        rst;
        logic        put;
        logic [7:0]  val;
        logic        ack;
        logic        e_rdy;
        logic        e_done;
        logic [3:0]  e_valid;
        logic [2:0]  e_cnt;
        logic [31:0] e_data;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  valid;
        logic [2:0]  cnt;
    } batch_t;

    vec_t   vecs[$];
    batch_t sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst_i, input logic put_i, input logic [7:0] val_i,
                                input logic ack_i, input logic rdy_i, input logic done_i,
                                input logic [3:0] valid_i, input logic [2:0] cnt_i,
                                input logic [31:0] data_i, input logic ovf_i);
        vec_t v;
        v.rst = rst_i; v.put = put_i; v.val = val_i; v.ack = ack_i;
        v.e_rdy = rdy_i; v.e_done = done_i; v.e_valid = valid_i;
        v.e_cnt = cnt_i; v.e_data = data_i; v.e_ovf = ovf_i;
        return v;
    endfunction

    initial begin
        batch_t exp_b;
        batch_t got_b;
        int     n;
        bit     seen;

        reset = 1'b1; put = 1'b0; val = 8'h00; ack = 1'b0;
        put1 = 1'b0; val1 = 8'h00; ack1 = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", odata, 32'h0);
        chk("rst_valid", ovalid, 4'h0);
        chk("rst_count", ocount, 3'd0);
        chk("rst_done", odone, 1'b0);
        chk("rst_ovf", oovf, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", rdy, 1'b1);

        // ---- vector table: rst put val ack | rdy done valid cnt data ovf ----
        // three values then publish
        vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 4'h0, 3'd0, 32'h00000000, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 1, 0, 4'h0, 3'd0, 32'h00000000, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1, 0, 4'h0, 3'd0, 32'h00000000, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 4'h7, 3'd3, 32'h00332211, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 4'h0, 3'd0, 32'h00332211, 0));
        // six values into four slots
        vecs.push_back(mk(0, 1, 8'h01, 0, 1, 0, 4'h0, 3'd0, 32'h00332211, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 1, 0, 4'h0, 3'd0, 32'h00332211, 0));
        vecs.push_back(mk(0, 1, 8'h03, 0, 1, 0, 4'h0, 3'd0, 32'h00332211, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0, 1, 0, 4'h0, 3'd0, 32'h00332211, 0));
        vecs.push_back(mk(0, 1, 8'h05, 0, 0, 0, 4'h0, 3'd0, 32'h00332211, 1));
        vecs.push_back(mk(0, 1, 8'h06, 0, 0, 0, 4'h0, 3'd0, 32'h00332211, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 4'hF, 3'd4, 32'h04030201, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 4'hF, 3'd4, 32'h04030201, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 4'h0, 3'd0, 32'h04030201, 0));
        // held batch, drop of 0x77 while waiting for acknowledge
        vecs.push_back(mk(0, 1, 8'h10, 0, 1, 0, 4'h0, 3'd0, 32'h04030201, 0));
        vecs.push_back(mk(0, 1, 8'h20, 0, 1, 0, 4'h0, 3'd0, 32'h04030201, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 4'h3, 3'd2, 32'h00002010, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 4'h3, 3'd2, 32'h00002010, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 4'h3, 3'd2, 32'h00002010, 0));
        vecs.push_back(mk(0, 1, 8'h77, 0, 0, 1, 4'h3, 3'd2, 32'h00002010, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 4'h3, 3'd2, 32'h00002010, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 4'h3, 3'd2, 32'h00002010, 1));
        // acknowledge together with a new value
        vecs.push_back(mk(0, 1, 8'hAA, 1, 1, 0, 4'h0, 3'd0, 32'h00002010, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 4'h1, 3'd1, 32'h000000AA, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 4'h0, 3'd0, 32'h000000AA, 0));
        // reset mid-collect: no publish afterwards
        vecs.push_back(mk(0, 1, 8'h01, 0, 1, 0, 4'h0, 3'd0, 32'h000000AA, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 1, 0, 4'h0, 3'd0, 32'h000000AA, 0));
        vecs.push_back(mk(1, 1, 8'h03, 1, 1, 0, 4'h0, 3'd0, 32'h00000000, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 4'h0, 3'd0, 32'h00000000, 0));
        // acknowledge outside HOLD is ignored
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 4'h0, 3'd0, 32'h00000000, 0));
        // reset while a batch is held
        vecs.push_back(mk(0, 1, 8'h44, 0, 1, 0, 4'h0, 3'd0, 32'h00000000, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 4'h1, 3'd1, 32'h00000044, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 4'h0, 3'd0, 32'h00000000, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 4'h0, 3'd0, 32'h00000000, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; put = vecs[i].put; val = vecs[i].val; ack = vecs[i].ack;
            #1;
            chk($sformatf("v%0d_ready", i), rdy, vecs[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done", i), odone, vecs[i].e_done);
            chk($sformatf("v%0d_valid", i), ovalid, vecs[i].e_valid);
            chk($sformatf("v%0d_count", i), ocount, vecs[i].e_cnt);
            chk($sformatf("v%0d_data", i), odata, vecs[i].e_data);
            chk($sformatf("v%0d_ovf", i), oovf, vecs[i].e_ovf);
        end

        // ---- scoreboard: random batches of 1..4 values ----
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 4);
            exp_b.data = 32'h0;
            exp_b.cnt = 3'(n);
            exp_b.valid = 4'((1 << n) - 1);
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                reset = 1'b0; ack = 1'b0; put = 1'b1;
                val = 8'($urandom_range(0, 255));
                exp_b.data[k*8 +: 8] = val;
            end
            sb_q.push_back(exp_b);
            @(negedge clk);
            put = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (odone) seen = 1'b1;
            end
            chk($sformatf("sb%0d_done_seen", b), seen, 1'b1);
            if (seen && sb_q.size() > 0) begin
                got_b = sb_q.pop_front();
                chk($sformatf("sb%0d_data", b), odata, got_b.data);
                chk($sformatf("sb%0d_valid", b), ovalid, got_b.valid);
                chk($sformatf("sb%0d_count", b), ocount, got_b.cnt);
            end
            @(negedge clk);
            ack = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("sb%0d_ack_done", b), odone, 1'b0);
            @(negedge clk);
            ack = 1'b0;
        end

        // ---- DEPTH=1 instance ----
        @(negedge clk);
        put1 = 1'b1; val1 = 8'h5A;
        #1;
        chk("d1_ready_first", rdy1, 1'b1);
        @(negedge clk);
        val1 = 8'h5B;
        #1;
        chk("d1_ready_full", rdy1, 1'b0);
        @(posedge clk);
        #1;
        chk("d1_ovf_set", oovf1, 1'b1);
        @(negedge clk);
        put1 = 1'b0;
        @(posedge clk);
        #1;
        chk("d1_done", odone1, 1'b1);
        chk("d1_data", odata1, 8'h5A);
        chk("d1_count", ocount1, 1'b1);
        chk("d1_valid", ovalid1, 1'b1);
        chk("d1_ovf", oovf1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
